// File: rtl/board_pkg.sv
// Shared types and constants for the board write sequencer.
// The watchdog constants are only used when BOARD_SEQ_TIMEOUT_EN is defined.
package board_pkg;

   localparam int BOARD_ROWS         = 20;
   localparam int BOARD_COLS         = 10;
   localparam int ROW_IDX_W          = 6;
   localparam int BOARD_MAX_ROWS     = 4;
   localparam int SLOT_W             = 2;
   localparam int SEQ_TIMEOUT_CYCLES = 16;
   localparam int TMO_CNT_W          = 5;

   localparam logic [TMO_CNT_W-1:0] TMO_LOAD = TMO_CNT_W'(SEQ_TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEL,
      S_SAVE,
      S_SAVE_WAIT,
      S_GAP,
      S_ANALY,
      S_ANALY_WAIT,
      S_DONE
   } seq_state_t;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_RANGE   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   // Timeout outranks a range error when both happened in one transaction.
   function automatic logic [1:0] seq_status(input logic tmo, input logic range_err);
      if (tmo) return ST_TIMEOUT;
      if (range_err) return ST_RANGE;
      return ST_OK;
   endfunction

endpackage

// File: rtl/board_write_sequencer_if.sv
// Lock handshake and row-store request bus of the board write sequencer.
// master = upstream placement logic plus row store, slave = the sequencer.
interface board_write_sequencer_if;
   import board_pkg::*;

   logic                                lock_valid;
   logic                                lock_ready;
   logic [BOARD_MAX_ROWS-1:0]           lock_mask;
   logic [ROW_IDX_W*BOARD_MAX_ROWS-1:0] lock_row_idx;
   logic [BOARD_COLS*BOARD_MAX_ROWS-1:0] lock_row_info;
   logic                                req_save_to_board;
   logic                                req_analy_to_board;
   logic [ROW_IDX_W-1:0]                row_idx;
   logic [BOARD_COLS-1:0]               row_info;
   logic                                ready_from_board;
   logic                                resp_from_board;
   logic                                busy;
   logic                                done;
   logic [1:0]                          done_status;

   modport master (
      output lock_valid, lock_mask, lock_row_idx, lock_row_info,
      output ready_from_board, resp_from_board,
      input  lock_ready, req_save_to_board, req_analy_to_board,
      input  row_idx, row_info, busy, done, done_status
   );

   modport slave (
      input  lock_valid, lock_mask, lock_row_idx, lock_row_info,
      input  ready_from_board, resp_from_board,
      output lock_ready, req_save_to_board, req_analy_to_board,
      output row_idx, row_info, busy, done, done_status
   );

endinterface

// File: rtl/board_slot_picker.sv
// Lowest-set-bit priority encoder over the remaining slot mask.
module board_slot_picker
   import board_pkg::*;
(
   input  logic [BOARD_MAX_ROWS-1:0] i_mask,
   output logic [SLOT_W-1:0]         o_slot,
   output logic                      o_empty
);

   always_comb begin
      o_slot  = '0;
      o_empty = (i_mask == '0);
      for (int k = BOARD_MAX_ROWS - 1; k >= 0; k--) begin
         if (i_mask[k]) o_slot = SLOT_W'(k);
      end
   end

endmodule

// File: rtl/board_write_sequencer.sv
// Issues one lock transaction to the row store as single-row saves plus one analysis.
// Optional store watchdog: BOARD_SEQ_TIMEOUT_EN.
//
// state        | meaning
// IDLE         | lock_ready high, waiting for a lock transaction
// SEL          | pick lowest remaining slot; skip out-of-range rows
// SAVE         | one-cycle save request
// SAVE_WAIT    | wait for store acknowledge of the save
// GAP          | wait for the store to report idle
// ANALY        | one-cycle analysis request
// ANALY_WAIT   | wait for store acknowledge of the analysis
// DONE         | one-cycle completion pulse with status
module board_write_sequencer
   import board_pkg::*;
#(
   parameter int ROWS = BOARD_ROWS
) (
   input logic                    clk,
   input logic                    rst_n,
   board_write_sequencer_if.slave bus
);

   seq_state_t                r_state, w_state_nxt;
   logic [BOARD_MAX_ROWS-1:0] r_mask;
   logic [ROW_IDX_W-1:0]      r_idx  [BOARD_MAX_ROWS];
   logic [BOARD_COLS-1:0]     r_info [BOARD_MAX_ROWS];
   logic                      r_range;

   logic                      r_lock_ready, r_busy, r_done, r_req_save, r_req_analy;
   logic [1:0]                r_done_status;
   logic [ROW_IDX_W-1:0]      r_row_idx;
   logic [BOARD_COLS-1:0]     r_row_info;

   logic [SLOT_W-1:0]         w_slot;
   logic                      w_empty;
   logic [ROW_IDX_W-1:0]      w_sel_idx;
   logic                      w_sel_legal;
   logic                      w_capture, w_load_row, w_skip_slot, w_tmo, w_tmo_fire;

   board_slot_picker u_picker (
      .i_mask  (r_mask),
      .o_slot  (w_slot),
      .o_empty (w_empty)
   );

   assign w_sel_idx   = r_idx[w_slot];
   assign w_sel_legal = (w_sel_idx < ROW_IDX_W'(ROWS));

`ifdef BOARD_SEQ_TIMEOUT_EN
   // Down-counter reloaded on every state change; terminal count means the store stalled.
   logic [TMO_CNT_W-1:0] r_tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_tmo_cnt <= TMO_LOAD;
      else if (w_state_nxt != r_state)   r_tmo_cnt <= TMO_LOAD;
      else if (r_tmo_cnt != '0)          r_tmo_cnt <= r_tmo_cnt - 1'b1;
   end

   assign w_tmo = (r_tmo_cnt == '0);
`else
   assign w_tmo = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_load_row  = 1'b0;
      w_skip_slot = 1'b0;
      w_tmo_fire  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.lock_valid && r_lock_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = S_SEL;
            end
         end
         S_SEL: begin
            if (w_empty) begin
               w_state_nxt = S_ANALY;
            end else if (!w_sel_legal) begin
               w_skip_slot = 1'b1;
            end else begin
               w_load_row  = 1'b1;
               w_state_nxt = S_SAVE;
            end
         end
         S_SAVE: w_state_nxt = S_SAVE_WAIT;
         S_SAVE_WAIT: begin
            if (bus.resp_from_board) begin
               w_state_nxt = S_GAP;
            end else if (w_tmo) begin
               w_tmo_fire  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_GAP: begin
            if (bus.ready_from_board) begin
               w_state_nxt = S_SEL;
            end else if (w_tmo) begin
               w_tmo_fire  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_ANALY: w_state_nxt = S_ANALY_WAIT;
         S_ANALY_WAIT: begin
            if (bus.resp_from_board) begin
               w_state_nxt = S_DONE;
            end else if (w_tmo) begin
               w_tmo_fire  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask        <= '0;
         r_range       <= 1'b0;
         for (int k = 0; k < BOARD_MAX_ROWS; k++) begin
            r_idx[k]  <= '0;
            r_info[k] <= '0;
         end
         r_lock_ready  <= 1'b1;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_req_save    <= 1'b0;
         r_req_analy   <= 1'b0;
         r_done_status <= ST_OK;
         r_row_idx     <= '0;
         r_row_info    <= '0;
      end else begin
         if (w_capture) begin
            r_mask  <= bus.lock_mask;
            r_range <= 1'b0;
            for (int k = 0; k < BOARD_MAX_ROWS; k++) begin
               r_idx[k]  <= bus.lock_row_idx[k*ROW_IDX_W +: ROW_IDX_W];
               r_info[k] <= bus.lock_row_info[k*BOARD_COLS +: BOARD_COLS];
            end
         end else if (w_tmo_fire) begin
            r_mask <= '0;
         end else if (w_skip_slot || w_load_row) begin
            r_mask[w_slot] <= 1'b0;
            if (w_skip_slot) r_range <= 1'b1;
         end
         if (w_load_row) begin
            r_row_idx  <= w_sel_idx;
            r_row_info <= r_info[w_slot];
         end
         r_lock_ready <= (w_state_nxt == S_IDLE);
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= (w_state_nxt == S_DONE);
         r_req_save   <= (w_state_nxt == S_SAVE);
         r_req_analy  <= (w_state_nxt == S_ANALY);
         if (w_state_nxt == S_DONE) r_done_status <= seq_status(w_tmo_fire, r_range);
      end
   end

   assign bus.lock_ready         = r_lock_ready;
   assign bus.busy               = r_busy;
   assign bus.done               = r_done;
   assign bus.done_status        = r_done_status;
   assign bus.req_save_to_board  = r_req_save;
   assign bus.req_analy_to_board = r_req_analy;
   assign bus.row_idx            = r_row_idx;
   assign bus.row_info           = r_row_info;

endmodule

// File: tb/tb_board_write_sequencer.sv
// Bench for board_write_sequencer: vector table plus reset, intrusion and stall sequences.
module tb_board_write_sequencer;
   import board_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   board_write_sequencer_if bus();
   board_write_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      logic [3:0]  mask;
      logic [23:0] idx;
      logic [39:0] info;
      int          rdy_dly;
      int          intrude;
      logic [1:0]  exp_status;
      int          exp_saves;
      int          exp_gap;
   } vec_t;

   typedef struct packed { logic [5:0] idx; logic [9:0] info; } save_t;
   typedef struct packed { logic [31:0] cyc; logic [5:0] idx; logic [9:0] info; } obs_save_t;
   typedef struct packed { logic [31:0] cyc; logic [1:0] st; } obs_done_t;

   localparam int NV = 7;
   vec_t vecs [NV];

   save_t      exp_q[$];
   logic [1:0] st_q[$];
   obs_save_t  obs_save_q[$];
   obs_done_t  obs_done_q[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int n_analy = 0;
   int n_inv = 0;
   int rdy_dly = 0;
   bit store_en = 1'b1;
   logic saw_req = 1'b0;
   int hold = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Row store model: acknowledges the cycle after a request, optional ready stretch.
   initial begin
      forever begin
         @(negedge clk);
         saw_req = bus.req_save_to_board | bus.req_analy_to_board;
      end
   end

   initial begin
      bus.resp_from_board  = 1'b0;
      bus.ready_from_board = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.resp_from_board = saw_req & store_en;
         if (saw_req) hold = rdy_dly;
         else if (hold > 0) hold--;
         bus.ready_from_board = (hold == 0);
      end
   end

   // Output monitor: records what the DUT produces.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (bus.req_save_to_board && bus.req_analy_to_board) n_inv++;
            if (bus.req_save_to_board)
               obs_save_q.push_back({32'(cyc), bus.row_idx, bus.row_info});
            if (bus.req_analy_to_board) n_analy++;
            if (bus.done) obs_done_q.push_back({32'(cyc), bus.done_status});
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_lock_ready"}, 32'(bus.lock_ready), 32'd1);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_status"}, 32'(bus.done_status), 32'd0);
      check({tag, "_req_save"}, 32'(bus.req_save_to_board), 32'd0);
      check({tag, "_req_analy"}, 32'(bus.req_analy_to_board), 32'd0);
      check({tag, "_row_idx"}, 32'(bus.row_idx), 32'd0);
      check({tag, "_row_info"}, 32'(bus.row_info), 32'd0);
   endtask

   task automatic wait_idle();
      int c = 0;
      while (!bus.lock_ready && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (!bus.lock_ready) begin
         n_vec++; n_err++;
         $display("FAIL wait_idle: lock_ready still 0 after %0d cycles", c);
      end
   endtask

   task automatic drive_lock(input logic [3:0] mask, input logic [23:0] idx,
                             input logic [39:0] info, input logic [1:0] st);
      logic [5:0] ix;
      @(negedge clk);
      bus.lock_valid    = 1'b1;
      bus.lock_mask     = mask;
      bus.lock_row_idx  = idx;
      bus.lock_row_info = info;
      for (int k = 0; k < 4; k++) begin
         ix = idx[6*k +: 6];
         if (mask[k] && ix < 6'd20) exp_q.push_back({ix, info[10*k +: 10]});
      end
      st_q.push_back(st);
      @(posedge clk);
      #1;
      bus.lock_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (!bus.done && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (!bus.done) begin
         n_vec++; n_err++;
         $display("FAIL wait_done: no done within %0d cycles", budget);
      end
      #1;
   endtask

   task automatic score(input int exp_saves, input int exp_gap,
                        output int t_last_save, output int t_done);
      obs_save_t o;
      save_t     e;
      obs_done_t d;
      int        prev = -1;
      t_done = -1;
      check("save_count", 32'(obs_save_q.size()), 32'(exp_saves));
      while (obs_save_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_save_q.pop_front();
         e = exp_q.pop_front();
         check("row_idx", 32'(o.idx), 32'(e.idx));
         check("row_info", 32'(o.info), 32'(e.info));
         if (prev >= 0) check("save_spacing", 32'(int'(o.cyc) - prev), 32'(exp_gap));
         prev = int'(o.cyc);
      end
      t_last_save = prev;
      obs_save_q.delete();
      exp_q.delete();
      check("done_count", 32'(obs_done_q.size()), 32'd1);
      if (obs_done_q.size() > 0 && st_q.size() > 0) begin
         d = obs_done_q.pop_front();
         check("done_status", 32'(d.st), 32'(st_q.pop_front()));
         t_done = int'(d.cyc);
      end
      obs_done_q.delete();
      st_q.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int a0, ls, td;
      rdy_dly = v.rdy_dly;
      wait_idle();
      a0 = n_analy;
      drive_lock(v.mask, v.idx, v.info, v.exp_status);
      if (v.intrude > 0) begin
         repeat (v.intrude) @(negedge clk);
         bus.lock_valid   = 1'b1;
         bus.lock_mask    = 4'hF;
         bus.lock_row_idx = {4{6'd9}};
         #1;
         check("intrude_lock_ready", 32'(bus.lock_ready), 32'd0);
         @(negedge clk);
         bus.lock_valid = 1'b0;
      end
      wait_done(300);
      score(v.exp_saves, v.exp_gap, ls, td);
      check("analy_count", 32'(n_analy - a0), 32'd1);
      @(negedge clk);
      check("idle_lock_ready", 32'(bus.lock_ready), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("done_pulse_width", 32'(bus.done), 32'd0);
   endtask

   initial begin
      int ls, td;
      bus.lock_valid    = 1'b0;
      bus.lock_mask     = '0;
      bus.lock_row_idx  = '0;
      bus.lock_row_info = '0;

      //            mask     idx {s3,s2,s1,s0}              info {s3,s2,s1,s0}                      dly intr status   n gap
      vecs[0] = '{4'b0101, {6'd0, 6'd7, 6'd0, 6'd3},     {10'h000, 10'h001, 10'h000, 10'h3FF}, 0, 0, ST_OK,    2, 4};
      vecs[1] = '{4'b0000, {6'd1, 6'd2, 6'd3, 6'd4},     {10'h111, 10'h222, 10'h333, 10'h044}, 0, 0, ST_OK,    0, 4};
      vecs[2] = '{4'b0011, {6'd0, 6'd0, 6'd19, 6'd25},   {10'h000, 10'h000, 10'h2A5, 10'h155}, 0, 0, ST_RANGE, 1, 4};
      vecs[3] = '{4'b1111, {6'd63, 6'd20, 6'd19, 6'd0},  {10'h3C3, 10'h0F0, 10'h00F, 10'h300}, 0, 0, ST_RANGE, 2, 4};
      vecs[4] = '{4'b1000, {6'd5, 6'd9, 6'd9, 6'd9},     {10'h2AA, 10'h111, 10'h111, 10'h111}, 0, 0, ST_OK,    1, 4};
      vecs[5] = '{4'b1111, {6'd4, 6'd3, 6'd2, 6'd1},     {10'h008, 10'h004, 10'h002, 10'h001}, 0, 3, ST_OK,    4, 4};
      vecs[6] = '{4'b1110, {6'd11, 6'd10, 6'd40, 6'd63}, {10'h0B0, 10'h0A0, 10'h3FF, 10'h3FF}, 3, 0, ST_RANGE, 2, 6};

      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Reset while waiting on the store acknowledge of a save.
      rdy_dly = 0;
      wait_idle();
      drive_lock(4'b0001, {18'd0, 6'd8}, {30'd0, 10'h0F0}, ST_OK);
      for (int c = 0; c < 20 && !bus.req_save_to_board; c++) @(negedge clk);
      check("pre_reset_save_seen", 32'(bus.req_save_to_board), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      repeat (2) @(negedge clk);
      check("rst_no_done", 32'(obs_done_q.size()), 32'd0);
      exp_q.delete(); st_q.delete(); obs_save_q.delete(); obs_done_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(vecs[0]);

      // Store that never acknowledges.
      store_en = 1'b0;
      wait_idle();
`ifdef BOARD_SEQ_TIMEOUT_EN
      drive_lock(4'b0001, {18'd0, 6'd2}, {30'd0, 10'h155}, ST_TIMEOUT);
      wait_done(100);
      score(1, 4, ls, td);
      check("timeout_latency", 32'(td - ls), 32'd17);
`else
      drive_lock(4'b0001, {18'd0, 6'd2}, {30'd0, 10'h155}, ST_OK);
      repeat (100) @(negedge clk);
      check("stall_busy", 32'(bus.busy), 32'd1);
      check("stall_no_done", 32'(obs_done_q.size()), 32'd0);
      check("stall_saves", 32'(obs_save_q.size()), 32'd1);
      check("stall_req_save_low", 32'(bus.req_save_to_board), 32'd0);
      check("stall_req_analy_low", 32'(bus.req_analy_to_board), 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      exp_q.delete(); st_q.delete(); obs_save_q.delete(); obs_done_q.delete();
      rst_n = 1'b1;
      @(negedge clk);
`endif
      store_en = 1'b1;

      check("req_exclusive", 32'(n_inv), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
